// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS32 decode/execute boundary: operand forward
// selects, control bundle width and the hardwired-zero register number.
package pipe_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CTRL_WIDTH = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] FWD_NONE  = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand resolution for both decode operands: picks bypass data
// or an EX-stage forward tag, and flags a load-use hazard.
module hazard_fwd_unit #(
    parameter int DATA_WIDTH = pipe_pkg::DATA_WIDTH
) (
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic                  uses_rt,
    input  logic [DATA_WIDTH-1:0] rf_data1,
    input  logic [DATA_WIDTH-1:0] rf_data2,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd,
    input  logic                  exmem_reg_write,
    input  logic                  exmem_mem_read,
    input  logic [4:0]            exmem_rd,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [4:0]            memwb_rd,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  load_use
);
    import pipe_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] value;
        logic [1:0]            fwd;
        logic                  hazard;
    } operand_t;

    operand_t res_a;
    operand_t res_b;

    // Youngest producer wins; a load still in EX cannot be bypassed at all, a
    // load in EX/MEM is picked up by the EX-stage mux from MEM/WB next cycle.
    function automatic operand_t resolve(input logic [4:0] src,
                                         input logic [DATA_WIDTH-1:0] rf);
        operand_t r;
        r = '{value: rf, fwd: FWD_NONE, hazard: 1'b0};
        if (src == REG_ZERO) begin
            r.value = '0;
        end else if (ex_valid && ex_reg_write && ex_rd == src) begin
            if (ex_mem_read) r.hazard = 1'b1;
            else             r.fwd    = FWD_EXMEM;
        end else if (exmem_reg_write && exmem_rd == src) begin
            if (exmem_mem_read) r.fwd   = FWD_MEMWB;
            else                r.value = exmem_result;
        end else if (memwb_reg_write && memwb_rd == src) begin
            r.value = memwb_result;
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a full assignment on each path, so no latch is inferred.
    always_comb begin
        res_a = resolve(rs, rf_data1);
        res_b = '{value: rf_data2, fwd: FWD_NONE, hazard: 1'b0};
        if (uses_rt) res_b = resolve(rt, rf_data2);
    end

    assign op_a     = res_a.value;
    assign op_b     = res_b.value;
    assign fwd_a    = res_a.fwd;
    assign fwd_b    = res_b.fwd;
    assign load_use = res_a.hazard | res_b.hazard;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use stall, branch flush
// and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int DATA_WIDTH = pipe_pkg::DATA_WIDTH,
    parameter int CTRL_WIDTH = pipe_pkg::CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic                  id_uses_rt,
    input  logic [4:0]            id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    output logic [4:0]            rf_rd_addr1,
    output logic [4:0]            rf_rd_addr2,
    input  logic [DATA_WIDTH-1:0] rf_rd_data1,
    input  logic [DATA_WIDTH-1:0] rf_rd_data2,
    input  logic                  exmem_reg_write,
    input  logic                  exmem_mem_read,
    input  logic [4:0]            exmem_rd,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [4:0]            memwb_rd,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [4:0]            ex_rs,
    output logic [4:0]            ex_rt,
    output logic [4:0]            ex_rd,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic [31:0]           stall_cnt
);
    import pipe_pkg::*;

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  load_use;

    assign rf_rd_addr1 = id_rs;
    assign rf_rd_addr2 = id_rt;

    hazard_fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_hazard_fwd (
        .rs              (id_rs),
        .rt              (id_rt),
        .uses_rt         (id_uses_rt),
        .rf_data1        (rf_rd_data1),
        .rf_data2        (rf_rd_data2),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .op_a            (op_a),
        .op_b            (op_b),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .load_use        (load_use)
    );

    // A taken branch kills the decode slot, so it never needs to wait.
    assign stall = rst_n & id_valid & load_use & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_fwd_a     <= FWD_NONE;
            ex_fwd_b     <= FWD_NONE;
            stall_cnt    <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;

            // Bubble only clears the qualifiers; the datapath fields are don't-care and hold.
            if (flush || stall) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_reg_write <= id_valid & id_reg_write;
                ex_mem_read  <= id_valid & id_mem_read;
                ex_rs        <= id_rs;
                ex_rt        <= id_rt;
                ex_rd        <= id_rd;
                ex_op_a      <= op_a;
                ex_op_b      <= op_b;
                ex_imm       <= id_imm;
                ex_ctrl      <= id_ctrl;
                ex_fwd_a     <= fwd_a;
                ex_fwd_b     <= fwd_b;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by
// randomized traffic compared against a producer-list reference model.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = CTRL_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] id_imm;
    logic [CW-1:0] id_ctrl;
    logic [4:0]    rf_rd_addr1, rf_rd_addr2;
    logic [DW-1:0] rf_rd_data1, rf_rd_data2;
    logic          exmem_reg_write, exmem_mem_read;
    logic [4:0]    exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [4:0]    memwb_rd;
    logic [DW-1:0] memwb_result;
    logic          flush, stall;
    logic          ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [1:0]    ex_fwd_a, ex_fwd_b;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the EX slot contents.
    bit          m_valid, m_rw, m_mr;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_a, m_b, m_imm;
    logic [CW-1:0] m_ctrl;
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_cnt;

    bit          e_stall;
    logic [31:0] e_a, e_b;
    logic [1:0]  e_fa, e_fb;
    logic        seen_stall;

    typedef struct {
        bit          wr;
        logic [4:0]  rd;
        bit          load;
        logic [31:0] val;
    } prod_t;

    // Producers listed youngest first: EX, EX/MEM, MEM/WB.
    function automatic void resolve(input logic [4:0] src, input logic [31:0] rf,
                                    output logic [31:0] v, output logic [1:0] f, output bit haz);
        prod_t p[3];
        p[0] = '{m_valid && m_rw, m_rd, m_mr, 32'd0};
        p[1] = '{exmem_reg_write, exmem_rd, exmem_mem_read, exmem_result};
        p[2] = '{memwb_reg_write, memwb_rd, 1'b0, memwb_result};
        v = rf; f = 2'd0; haz = 1'b0;
        if (src == 5'd0) begin
            v = 32'd0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (p[i].wr && p[i].rd == src) begin
                case (i)
                    0:       if (p[i].load) haz = 1'b1; else f = 2'd1;
                    1:       if (p[i].load) f = 2'd2; else v = p[i].val;
                    default: v = p[i].val;
                endcase
                return;
            end
        end
    endfunction

    task automatic model_comb();
        bit ha, hb;
        resolve(id_rs, rf_rd_data1, e_a, e_fa, ha);
        hb = 1'b0;
        if (id_uses_rt) resolve(id_rt, rf_rd_data2, e_b, e_fb, hb);
        else begin e_b = rf_rd_data2; e_fb = 2'd0; end
        e_stall = rst_n && id_valid && (ha || hb) && !flush;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            {m_valid, m_rw, m_mr} = 3'b000;
            m_rs = 0; m_rt = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
            m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            if (e_stall && 64'(m_cnt) + 64'd1 <= 64'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (flush || e_stall) begin
                {m_valid, m_rw, m_mr} = 3'b000;
            end else begin
                m_valid = id_valid;
                m_rw = id_valid && id_reg_write;
                m_mr = id_valid && id_mem_read;
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
                m_a = e_a; m_b = e_b; m_imm = id_imm; m_ctrl = id_ctrl;
                m_fa = e_fa; m_fb = e_fb;
            end
        end
    endtask

    task automatic compare_outputs();
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        check("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
        check("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        check("ex_rs", 32'(ex_rs), 32'(m_rs));
        check("ex_rt", 32'(ex_rt), 32'(m_rt));
        check("ex_rd", 32'(ex_rd), 32'(m_rd));
        check("ex_op_a", ex_op_a, m_a);
        check("ex_op_b", ex_op_b, m_b);
        check("ex_imm", ex_imm, m_imm);
        check("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        check("ex_fwd_a", 32'(ex_fwd_a), 32'(m_fa));
        check("ex_fwd_b", 32'(ex_fwd_b), 32'(m_fb));
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic cycle();
        #1;
        model_comb();
        seen_stall = stall;
        check("stall", 32'(stall), 32'(e_stall));
        check("rf_rd_addr1", 32'(rf_rd_addr1), 32'(id_rs));
        check("rf_rd_addr2", 32'(rf_rd_addr2), 32'(id_rt));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle();
        rst_n = 1'b1; id_valid = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_ctrl = 0;
        rf_rd_data1 = 0; rf_rd_data2 = 0;
        exmem_reg_write = 0; exmem_mem_read = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0; flush = 0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        id_imm = $urandom; id_ctrl = CW'($urandom);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        cycle();
        check("reset ex_valid", 32'(ex_valid), 32'd0);
        check("reset stall_cnt", stall_cnt, 32'd0);

        // Independent add r6 = r3 + r4.
        idle();
        set_id(5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        rf_rd_data1 = 32'd3; rf_rd_data2 = 32'd4;
        cycle();
        check("add op_a", ex_op_a, 32'd3);
        check("add op_b", ex_op_b, 32'd4);
        check("add fwd", 32'({ex_fwd_a, ex_fwd_b}), 32'd0);
        check("add stall", 32'(seen_stall), 32'd0);

        // ALU producer of r5 then consumer: EX-stage forward, no stall.
        set_id(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(5'd5, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        cycle();
        check("alu dep stall", 32'(seen_stall), 32'd0);
        check("alu dep fwd_a", 32'(ex_fwd_a), 32'd1);

        // Load r5 then consumer: one stall cycle, bubble, then fwd=2.
        set_id(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle();
        set_id(5'd5, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
        cycle();
        check("load-use stall", 32'(seen_stall), 32'd1);
        check("load-use bubble", 32'(ex_valid), 32'd0);
        exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_rd = 5'd5;
        cycle();
        check("load-use second stall", 32'(seen_stall), 32'd0);
        check("load-use ex_valid", 32'(ex_valid), 32'd1);
        check("load-use fwd_a", 32'(ex_fwd_a), 32'd2);
        check("load-use stall_cnt", stall_cnt, 32'd1);

        // MEM/WB write-through of r7 while the register file still holds old data.
        idle();
        set_id(5'd7, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        rf_rd_data1 = 32'h0000_1111;
        memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_result = 32'hDEAD_BEEF;
        cycle();
        check("write-through op_a", ex_op_a, 32'hDEAD_BEEF);
        set_id(5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        rf_rd_data1 = 32'h5555_5555; memwb_rd = 5'd0;
        cycle();
        check("r0 op_a", ex_op_a, 32'd0);

        // Flush coinciding with a load-use hazard.
        idle();
        set_id(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        cycle();
        set_id(5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        flush = 1'b1;
        cycle();
        check("flush stall", 32'(seen_stall), 32'd0);
        check("flush ex_valid", 32'(ex_valid), 32'd0);
        check("flush ex_reg_write", 32'(ex_reg_write), 32'd0);

        // Saturation: preload near the top, then lw r5,0(r5) stalls every other cycle.
        idle();
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFF_FFFD;
        set_id(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        check("saturated stall_cnt", stall_cnt, 32'hFFFF_FFFF);

        // Reset arriving while a stall is pending.
        cycle();
        rst_n = 1'b0;
        cycle();
        check("reset mid-stall stall", 32'(seen_stall), 32'd0);
        check("reset mid-stall ex_valid", 32'(ex_valid), 32'd0);
        check("reset mid-stall stall_cnt", stall_cnt, 32'd0);

        // Randomized traffic with a narrow register range to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            id_valid = ($urandom_range(0, 7) != 0);
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_uses_rt = 1'($urandom);
            id_reg_write = 1'($urandom);
            id_mem_read = 1'($urandom);
            id_imm = $urandom; id_ctrl = CW'($urandom);
            rf_rd_data1 = $urandom; rf_rd_data2 = $urandom;
            exmem_reg_write = 1'($urandom); exmem_mem_read = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
